// File: rtl/lc4_isa_pkg.sv
// LC4/ECC instruction-set constants shared by the encoder, packer and assembler tests.
package lc4_isa_pkg;

  localparam int unsigned INSN_W = 20;
  localparam int unsigned OPC_W  = 5;

  localparam int unsigned OPC_HI = 19;
  localparam int unsigned OPC_LO = 15;
  localparam int unsigned RD_HI  = 14;
  localparam int unsigned RD_LO  = 10;
  localparam int unsigned RS_HI  = 9;
  localparam int unsigned RS_LO  = 5;
  localparam int unsigned RT_HI  = 4;
  localparam int unsigned RT_LO  = 0;

  localparam logic [OPC_W-1:0] OP_NOP   = 5'b00000;
  localparam logic [OPC_W-1:0] OP_BRZ   = 5'b00001;
  localparam logic [OPC_W-1:0] OP_BRN   = 5'b00010;
  localparam logic [OPC_W-1:0] OP_BRP   = 5'b00011;
  localparam logic [OPC_W-1:0] OP_BRA   = 5'b00100;
  localparam logic [OPC_W-1:0] OP_ADD   = 5'b00101;
  localparam logic [OPC_W-1:0] OP_SUB   = 5'b00110;
  localparam logic [OPC_W-1:0] OP_ADDI  = 5'b00111;
  localparam logic [OPC_W-1:0] OP_JSR   = 5'b01000;
  localparam logic [OPC_W-1:0] OP_ANDI  = 5'b01001;
  localparam logic [OPC_W-1:0] OP_RTI   = 5'b01010;
  localparam logic [OPC_W-1:0] OP_CONST = 5'b01011;
  localparam logic [OPC_W-1:0] OP_MUL   = 5'b01100;
  localparam logic [OPC_W-1:0] OP_AND   = 5'b01101;
  localparam logic [OPC_W-1:0] OP_OR    = 5'b01110;
  localparam logic [OPC_W-1:0] OP_XOR   = 5'b01111;
  localparam logic [OPC_W-1:0] OP_CHKL  = 5'b10000;
  localparam logic [OPC_W-1:0] OP_TCDL  = 5'b10010;
  localparam logic [OPC_W-1:0] OP_CHKH  = 5'b10011;
  localparam logic [OPC_W-1:0] OP_SHF   = 5'b10100;
  localparam logic [OPC_W-1:0] OP_TCDH  = 5'b10101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } enc_state_t;

endpackage

// File: rtl/lc4_insn_pack.sv
// Combinational field packer: opcode/rd/rs/rt/imm -> 20-bit LC4/ECC word plus illegal flag.
module lc4_insn_pack
  import lc4_isa_pkg::*;
(
  input  logic [OPC_W-1:0]  opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [9:0]        imm,
  output logic [INSN_W-1:0] word,
  output logic              illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR, OP_TCDL, OP_SHF, OP_TCDH:
        word = {opcode, rd, rs, rt};
      OP_ADDI, OP_ANDI:
        word = {opcode, rd, rs, imm[4:0]};
      OP_CHKL, OP_CHKH:
        word = {opcode, rd, rs, 5'b0};
      OP_CONST:
        word = {opcode, rd, imm};
      // JSR always links through r7 in hardware, so its rd field stays zero
      OP_NOP, OP_BRZ, OP_BRN, OP_BRP, OP_BRA, OP_JSR:
        word = {opcode, 5'b0, imm};
      OP_RTI:
        word = {opcode, 15'b0};
      default: begin
        word    = '0;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/lc4_insn_encoder.sv
// Program loader: packs field bundles into LC4/ECC words, buffers them and writes imem.
// Optional LC4_ENC_CHECKSUM_EN adds a running XOR of the words written in the current load.
module lc4_insn_encoder
  import lc4_isa_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPC_W-1:0]  in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [9:0]        in_imm,
  input  logic              mem_stall,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [INSN_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
`ifdef LC4_ENC_CHECKSUM_EN
  output logic [INSN_W-1:0] checksum,
`endif
  output logic              err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  enc_state_t state, state_nxt;

  logic [ADDR_W-1:0] base_q, len_q, acc_cnt, wr_cnt;
  logic [INSN_W-1:0] fifo_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  fifo_cnt;
  logic              fifo_full, fifo_empty;
  logic              start_load, push, pop;
  logic [INSN_W-1:0] pack_word;
  logic              pack_illegal;

  lc4_insn_pack u_pack (
    .opcode  (in_opcode),
    .rd      (in_rd),
    .rs      (in_rs),
    .rt      (in_rt),
    .imm     (in_imm),
    .word    (pack_word),
    .illegal (pack_illegal)
  );

  assign fifo_full  = (fifo_cnt == CNT_W'(DEPTH));
  assign fifo_empty = (fifo_cnt == '0);
  assign start_load = (state == ST_IDLE) && start;

  assign in_ready  = (state == ST_LOAD) && !fifo_full && (acc_cnt < len_q);
  assign mem_we    = (state == ST_LOAD) && !fifo_empty && !mem_stall;
  assign mem_addr  = base_q + wr_cnt;
  assign mem_wdata = fifo_empty ? '0 : fifo_mem[rd_ptr];
  assign busy      = (state == ST_LOAD);
  assign done      = (state == ST_DONE);
  assign push      = in_valid && in_ready;
  assign pop       = mem_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_LOAD;
      ST_LOAD: if ((acc_cnt == len_q) && fifo_empty && !mem_we) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Load bookkeeping and FIFO pointers; a new start discards anything left over.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q   <= '0;
      len_q    <= '0;
      acc_cnt  <= '0;
      wr_cnt   <= '0;
      err      <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (start_load) begin
      base_q   <= base_addr;
      len_q    <= len;
      acc_cnt  <= '0;
      wr_cnt   <= '0;
      err      <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        acc_cnt <= acc_cnt + ADDR_W'(1);
        wr_ptr  <= wr_ptr + PTR_W'(1);
        if (pack_illegal) err <= 1'b1;
      end
      if (pop) begin
        wr_cnt <= wr_cnt + ADDR_W'(1);
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop)      fifo_cnt <= fifo_cnt + CNT_W'(1);
      else if (pop && !push) fifo_cnt <= fifo_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= pack_word;
  end

`ifdef LC4_ENC_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             checksum <= '0;
    else if (start_load) checksum <= '0;
    else if (pop)        checksum <= checksum ^ mem_wdata;
  end
`endif

endmodule
